avalon_fb_writer: RTL and testbench
===================================

// Module: avalon_fb_writer
// PURPOSE
//  HPS-to-framebuffer bridge. Avalon-MM slave on the HPS-FPGA bridge; writes and reads
//  24-bit pixels in the framebuffer RAM that PixelStream scans out to the ADV7513.
//  Also provides a hardware fill engine that clears the framebuffer to one colour.
//  Feeds PixelStream's memory write port. Runs entirely in the pixel-memory clock domain.
// PARAMETERS
//  ADDR_W   16       framebuffer word-address width (matches PixelAddr pix_addr)
//  FB_DEPTH 65536    number of pixels; fill runs over 0..FB_DEPTH-1
// PORTS
//  Clock                 in   1   single clock, rising edge
//  Reset                 in   1   synchronous, active-high
//  Avalon_Address        in   19  word address
//  Avalon_Read           in   1   read request
//  Avalon_Write          in   1   write request
//  Avalon_WriteData      in   32  [23:0] = RGB pixel / register data
//  Avalon_WaitRequest    out  1   stall; request is held by master while high
//  Avalon_ReadData       out  32  read data
//  Avalon_ReadDataValid  out  1   one-cycle strobe, qualifies ReadData
//  fb_we                 out  1   framebuffer write enable
//  fb_addr               out  ADDR_W  framebuffer address (shared by reads and writes)
//  fb_wdata              out  24  framebuffer write data
//  fb_rdata              in   24  framebuffer read data; valid 1 cycle after fb_addr
//  busy                  out  1   fill engine active
// BEHAVIOUR
//  Decided: one clock (Clock); Reset is synchronous and active-high.
//  Reset: WaitRequest=0, ReadDataValid=0, ReadData=0, fb_we=0, fb_addr=0, fb_wdata=0,
//   busy=0, FILL_COLOUR=0, state=IDLE. Reset mid-fill aborts the fill next edge.
//  Address map (word address):
//   A[18]=0, A[17:ADDR_W]=0  -> pixel A[ADDR_W-1:0]
//   A[18]=0, other high bits  -> unmapped: write ignored; read returns 0 (still valid)
//   A[18]=1, A[1:0]=0 FILL_COLOUR (RW, 24b)   =1 FILL_GO (W: any write starts fill)
//            =2 STATUS (RO, bit0=busy)         =3 reserved (RAZ/WI)
//  Requests are accepted when WaitRequest=0. If Read and Write are both high,
//   Write wins and Read is ignored.
//  Pixel write: accepted in cycle N -> fb_we=1, fb_addr, and fb_wdata=WriteData[23:0] in N+1.
//  Pixel read: accepted in N -> fb_addr driven in N+1 -> ReadData={8'h0,fb_rdata},
//   ReadDataValid=1 in N+2. At most one read is outstanding: WaitRequest=1 in N+1.
//  Register read: ReadDataValid=1 in N+1, zero-extended to 32 bits.
//  FSM: IDLE -> RD_WAIT (pixel read) -> RD_DATA -> IDLE.
//       IDLE -> FILL (on a FILL_GO write).
//  FILL state:
//   - fb_we=1 every cycle; fb_addr counts 0..FB_DEPTH-1; fb_wdata=FILL_COLOUR
//     latched at GO; busy=1.
//   - The cycle after the write to FB_DEPTH-1 completes: return to IDLE, busy=0.
//   - Total duration: FB_DEPTH cycles. The address counter must not wrap.
//  During FILL:
//   - Pixel accesses: WaitRequest=1 (stalled until the fill ends).
//   - Register accesses: served normally.
//   - FILL_COLOUR writes update the register but do not affect the fill in progress.
//   - A FILL_GO write is ignored (no restart).
//  fb_we is never high outside pixel-write cycles and FILL.
// STRUCTURE
//  Shared package (fb_pkg): ADDR_W, FB_DEPTH, register offsets (REG_FILL_COLOUR=0,
//   REG_FILL_GO=1, REG_STATUS=2), FSM state encoding.
//  One natural sub-module: fb_fill_engine (address counter, colour latch, done flag);
//   Avalon decode and the FSM stay in the top.
// TESTING
//  1 Reset held 3 cycles -> all outputs 0; STATUS reads 0.
//  2 Write 0x00000123 data 0x00ABCDEF -> next cycle fb_we=1, fb_addr=0x0123,
//     fb_wdata=0xABCDEF; read 0x0123 (model RAM) -> ReadDataValid 2 cycles later,
//     ReadData=0x00ABCDEF.
//  3 Write 0x40000=0x112233, then 0x40001 -> busy=1 for exactly 65536 cycles,
//     every fb addr 0..0xFFFF written with 0x112233, no wrap to 0.
//  4 Mid-fill pixel write -> WaitRequest=1 until busy drops, then write lands;
//     mid-fill STATUS read -> 0x1 with no stall.
//  5 Read and Write high together at pixel 0x10 -> only the write occurs;
//     no ReadDataValid. Unmapped read 0x20000 -> ReadData=0, valid.
//  6 Reset asserted at fill address 0x100 -> busy=0 and fb_we=0 next cycle;
//     a new GO restarts from address 0.

Source files
------------

// File: rtl/avalon_fb_writer_pkg.sv
// Shared constants, register offsets and FSM encoding for the HPS-to-framebuffer bridge.
package avalon_fb_writer_pkg;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned FB_DEPTH = 65536;

  localparam logic [1:0] REG_FILL_COLOUR = 2'd0;
  localparam logic [1:0] REG_FILL_GO     = 2'd1;
  localparam logic [1:0] REG_STATUS      = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_DATA,
    ST_FILL
  } state_t;

endpackage

// File: rtl/avalon_fb_writer_if.sv
// Avalon-MM slave bus between the HPS-FPGA bridge and the framebuffer writer.
interface avalon_fb_writer_if;

  logic [18:0] address;
  logic        read;
  logic        write;
  logic [31:0] write_data;
  logic        wait_request;
  logic [31:0] read_data;
  logic        read_data_valid;

  modport slave (
    input  address, read, write, write_data,
    output wait_request, read_data, read_data_valid
  );

  modport master (
    output address, read, write, write_data,
    input  wait_request, read_data, read_data_valid
  );

endinterface

// File: rtl/avalon_fb_writer_fill_engine.sv
// Fill engine: walks the framebuffer address space once with a colour latched at start.
module fb_fill_engine #(
  parameter int unsigned ADDR_W   = avalon_fb_writer_pkg::ADDR_W,
  parameter int unsigned FB_DEPTH = avalon_fb_writer_pkg::FB_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              run,
  input  logic [23:0]       colour_in,
  output logic [ADDR_W-1:0] addr,
  output logic [23:0]       colour,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  // Counter holds at the last address so it can never wrap back to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr   <= '0;
      colour <= '0;
    end else if (start) begin
      addr   <= '0;
      colour <= colour_in;
    end else if (run && !done) begin
      addr <= addr + ADDR_W'(1);
    end
  end

  assign done = (addr == LAST_ADDR);

endmodule

// File: rtl/avalon_fb_writer.sv
// Avalon-MM slave that writes/reads framebuffer pixels and runs a hardware colour fill.
module avalon_fb_writer #(
  parameter int unsigned ADDR_W   = avalon_fb_writer_pkg::ADDR_W,
  parameter int unsigned FB_DEPTH = avalon_fb_writer_pkg::FB_DEPTH
) (
  input  logic               Clock,
  input  logic               Reset,
  avalon_fb_writer_if.slave  avs,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [23:0]        fb_wdata,
  input  logic [23:0]        fb_rdata,
  output logic               busy
);

  import avalon_fb_writer_pkg::*;

  state_t state, state_nxt;

  logic [23:0]       fill_colour;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [23:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              rvalid_q;

  logic              is_reg, is_pix, stall, wr_acc, rd_acc, fill_start, fill_done;
  logic [1:0]        reg_off;
  logic [31:0]       reg_rdata;
  logic [ADDR_W-1:0] fill_addr;
  logic [23:0]       fill_wdata;
  logic              unused_bits;

  assign unused_bits = ^avs.write_data[31:24];

  always_comb begin
    reg_off   = avs.address[1:0];
    is_reg    = avs.address[18];
    is_pix    = !avs.address[18] && (avs.address[17:ADDR_W] == '0);
    stall     = 1'b0;
    reg_rdata = '0;
    case (state)
      ST_RD_WAIT, ST_RD_DATA: stall = 1'b1;
      ST_FILL:                stall = is_pix && (avs.read || avs.write);
      default:                stall = 1'b0;
    endcase
    // Write takes priority when the master raises both strobes.
    wr_acc     = avs.write && !stall;
    rd_acc     = avs.read && !avs.write && !stall;
    fill_start = wr_acc && is_reg && (reg_off == REG_FILL_GO) && (state != ST_FILL);
    case (reg_off)
      REG_FILL_COLOUR: reg_rdata = {8'h00, fill_colour};
      REG_STATUS:      reg_rdata = {31'h0, busy};
      default:         reg_rdata = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (fill_start)            state_nxt = ST_FILL;
        else if (rd_acc && is_pix) state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: state_nxt = ST_RD_DATA;
      ST_RD_DATA: state_nxt = ST_IDLE;
      ST_FILL:    if (fill_done) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= ST_IDLE;
      fill_colour <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      we_q     <= wr_acc && is_pix;
      rvalid_q <= rd_acc && !is_pix;
      if ((wr_acc || rd_acc) && is_pix)
        addr_q <= avs.address[ADDR_W-1:0];
      if (wr_acc && is_pix)
        wdata_q <= avs.write_data[23:0];
      if (wr_acc && is_reg && (reg_off == REG_FILL_COLOUR))
        fill_colour <= avs.write_data[23:0];
      if (rd_acc && !is_pix)
        rdata_q <= is_reg ? reg_rdata : '0;
    end
  end

  fb_fill_engine #(
    .ADDR_W   (ADDR_W),
    .FB_DEPTH (FB_DEPTH)
  ) u_fill (
    .clk       (Clock),
    .rst       (Reset),
    .start     (fill_start),
    .run       (busy),
    .colour_in (fill_colour),
    .addr      (fill_addr),
    .colour    (fill_wdata),
    .done      (fill_done)
  );

  // Pixel read data comes straight from the RAM port in the cycle it becomes valid.
  always_comb begin
    busy                = (state == ST_FILL);
    fb_we               = busy ? 1'b1 : we_q;
    fb_addr             = busy ? fill_addr : addr_q;
    fb_wdata            = busy ? fill_wdata : wdata_q;
    avs.wait_request    = stall;
    avs.read_data       = (state == ST_RD_DATA) ? {8'h00, fb_rdata} : rdata_q;
    avs.read_data_valid = rvalid_q || (state == ST_RD_DATA);
  end

endmodule

// File: tb/tb_avalon_fb_writer.sv
// Directed bench for avalon_fb_writer with a queue-based behavioural model and framebuffer RAM.
module tb_avalon_fb_writer;

  localparam int unsigned DEPTH = 65536;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [23:0] fb_wdata;
  logic [23:0] fb_rdata;
  logic        busy;

  always #5 Clock = ~Clock;

  avalon_fb_writer_if avs ();

  avalon_fb_writer #(.ADDR_W(16), .FB_DEPTH(DEPTH)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .avs      (avs),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_wdata (fb_wdata),
    .fb_rdata (fb_rdata),
    .busy     (busy)
  );

  logic [23:0] ram [DEPTH];
  logic [23:0] img [DEPTH];

  always @(posedge Clock) begin
    if (fb_we) ram[fb_addr] <= fb_wdata;
    fb_rdata <= ram[fb_addr];
  end

  typedef struct { logic [15:0] a; logic [23:0] d; } wr_t;
  typedef struct { int due; logic [31:0] d; } rd_t;

  wr_t         wq[$];
  rd_t         rq[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          fill_left = 0;
  bit          cur_busy = 1'b0;
  logic [23:0] m_colour = '0;
  int          busy_run = 0;
  int          last_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_accept(input bit rd, input bit wr, input logic [18:0] a,
                                       input logic [31:0] d);
    wr_t w;
    rd_t r;
    if (wr) begin
      if (a[18]) begin
        if (a[1:0] == 2'd0) m_colour = d[23:0];
        else if (a[1:0] == 2'd1 && !cur_busy) begin
          for (int i = 0; i < DEPTH; i++) begin
            w.a = 16'(i);
            w.d = m_colour;
            wq.push_back(w);
          end
          fill_left = DEPTH;
        end
      end else if (a[17:16] == 2'b00) begin
        w.a = a[15:0];
        w.d = d[23:0];
        wq.push_back(w);
      end
    end else if (rd) begin
      if (a[18]) begin
        r.due = cyc + 1;
        if (a[1:0] == 2'd0)      r.d = {8'h00, m_colour};
        else if (a[1:0] == 2'd2) r.d = {31'h0, cur_busy};
        else                     r.d = 32'h0;
      end else if (a[17:16] == 2'b00) begin
        r.due = cyc + 2;
        r.d   = {8'h00, img[a[15:0]]};
      end else begin
        r.due = cyc + 1;
        r.d   = 32'h0;
      end
      rq.push_back(r);
    end
  endfunction

  // Per-cycle compare: 3 ns after each rising edge, against the model queues.
  initial begin
    bit  r;
    wr_t w;
    rd_t rr;
    forever begin
      @(posedge Clock);
      r = Reset;
      #3;
      cyc++;
      if (r) begin
        wq.delete();
        rq.delete();
        fill_left = 0;
        cur_busy  = 1'b0;
        m_colour  = '0;
        busy_run  = 0;
        check("rst_ctl", {28'h0, fb_we, busy, avs.wait_request, avs.read_data_valid}, 32'h0);
        check("rst_fb_addr", 32'(fb_addr), 32'h0);
        check("rst_fb_wdata", 32'(fb_wdata), 32'h0);
        check("rst_read_data", avs.read_data, 32'h0);
      end else begin
        cur_busy = (fill_left > 0);
        if (fill_left > 0) fill_left--;
        check("busy", 32'(busy), 32'(cur_busy));
        if (busy) busy_run++;
        else if (busy_run > 0) begin
          last_run = busy_run;
          busy_run = 0;
        end
        if (wq.size() > 0) begin
          w = wq.pop_front();
          check("fb_we", 32'(fb_we), 32'd1);
          check("fb_addr", 32'(fb_addr), 32'(w.a));
          check("fb_wdata", 32'(fb_wdata), 32'(w.d));
          img[w.a] = w.d;
        end else begin
          check("fb_we_idle", 32'(fb_we), 32'd0);
        end
        if (rq.size() > 0 && rq[0].due == cyc) begin
          rr = rq.pop_front();
          check("rvalid", 32'(avs.read_data_valid), 32'd1);
          check("read_data", avs.read_data, rr.d);
        end else begin
          check("rvalid_idle", 32'(avs.read_data_valid), 32'd0);
        end
      end
    end
  end

  task automatic bus(input bit rd, input bit wr, input logic [18:0] a, input logic [31:0] d,
                     output int stall, output logic [31:0] rdata);
    bit acc = 1'b0;
    bit got = 1'b0;
    stall = 0;
    rdata = '0;
    @(posedge Clock);
    #1;
    avs.address    = a;
    avs.read       = rd;
    avs.write      = wr;
    avs.write_data = d;
    while (!acc && stall < 70000) begin
      @(negedge Clock);
      if (!avs.wait_request) begin
        acc = 1'b1;
        model_accept(rd, wr, a, d);
      end else begin
        stall++;
      end
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: addr %h still stalled after %0d cycles", a, stall);
    end
    @(posedge Clock);
    #1;
    avs.read  = 1'b0;
    avs.write = 1'b0;
    if (acc && rd && !wr) begin
      for (int k = 0; k < 8 && !got; k++) begin
        if (avs.read_data_valid) begin
          rdata = avs.read_data;
          got   = 1'b1;
        end else begin
          @(posedge Clock);
          #1;
        end
      end
      if (!got) begin
        vectors++;
        miscompares++;
        $display("FAIL read_timeout: addr %h got no ReadDataValid, required one", a);
      end
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          st;
    logic [31:0] rd;
    bit          found;
    avs.address    = '0;
    avs.read       = 1'b0;
    avs.write      = 1'b0;
    avs.write_data = '0;
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;

    bus(1'b1, 1'b0, 19'h40002, 32'h0, st, rd);
    check("status_after_reset", rd, 32'h0);

    bus(1'b0, 1'b1, 19'h00123, 32'h00ABCDEF, st, rd);
    check("pix_wr_we", 32'(fb_we), 32'd1);
    check("pix_wr_addr", 32'(fb_addr), 32'h0123);
    check("pix_wr_data", 32'(fb_wdata), 32'hABCDEF);
    bus(1'b1, 1'b0, 19'h00123, 32'h0, st, rd);
    check("pix_rd", rd, 32'h00ABCDEF);

    bus(1'b1, 1'b1, 19'h00010, 32'h00DDEEFF, st, rd);
    bus(1'b1, 1'b0, 19'h00010, 32'h0, st, rd);
    check("rw_both_write_landed", rd, 32'h00DDEEFF);
    bus(1'b1, 1'b0, 19'h20000, 32'h0, st, rd);
    check("unmapped_rd", rd, 32'h0);
    bus(1'b0, 1'b1, 19'h10005, 32'h00123456, st, rd);
    bus(1'b1, 1'b0, 19'h40003, 32'h0, st, rd);
    check("reserved_rd", rd, 32'h0);

    bus(1'b0, 1'b1, 19'h40000, 32'h00112233, st, rd);
    bus(1'b1, 1'b0, 19'h40000, 32'h0, st, rd);
    check("colour_rd", rd, 32'h00112233);
    bus(1'b0, 1'b1, 19'h40001, 32'h0, st, rd);
    check("fill_first_addr", 32'(fb_addr), 32'h0);
    check("fill_busy", 32'(busy), 32'd1);
    bus(1'b1, 1'b0, 19'h40002, 32'h0, st, rd);
    check("status_mid_fill", rd, 32'h1);
    check("status_no_stall", 32'(st), 32'd0);
    bus(1'b0, 1'b1, 19'h40000, 32'h00445566, st, rd);
    bus(1'b0, 1'b1, 19'h40001, 32'h0, st, rd);
    bus(1'b0, 1'b1, 19'h00055, 32'h00778899, st, rd);
    check("stalled_wr_busy_done", 32'(busy), 32'd0);
    check("stalled_wr_addr", 32'(fb_addr), 32'h0055);
    check("stalled_wr_data", 32'(fb_wdata), 32'h778899);
    check("busy_cycles", 32'(last_run), 32'd65536);
    bus(1'b1, 1'b0, 19'h00055, 32'h0, st, rd);
    check("rd_after_fill_55", rd, 32'h00778899);
    bus(1'b1, 1'b0, 19'h0FFFF, 32'h0, st, rd);
    check("rd_fill_last", rd, 32'h00112233);
    bus(1'b1, 1'b0, 19'h00123, 32'h0, st, rd);
    check("rd_fill_overwrote", rd, 32'h00112233);
    bus(1'b1, 1'b0, 19'h40000, 32'h0, st, rd);
    check("colour_updated", rd, 32'h00445566);
    check("wq_drained", 32'(wq.size()), 32'd0);

    bus(1'b0, 1'b1, 19'h40001, 32'h0, st, rd);
    found = 1'b0;
    for (int k = 0; k < 512 && !found; k++) begin
      @(posedge Clock);
      #1;
      if (fb_addr == 16'h0100) found = 1'b1;
    end
    check("fill_reached_100", 32'(found), 32'd1);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_we", 32'(fb_we), 32'd0);
    Reset = 1'b0;

    bus(1'b0, 1'b1, 19'h40000, 32'h000000AA, st, rd);
    bus(1'b0, 1'b1, 19'h40001, 32'h0, st, rd);
    check("restart_addr", 32'(fb_addr), 32'h0);
    check("restart_data", 32'(fb_wdata), 32'hAA);
    repeat (16) @(posedge Clock);
    #1;
    check("restart_addr_16", 32'(fb_addr), 32'h10);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    repeat (4) @(posedge Clock);
    #4;
    check("wq_empty_end", 32'(wq.size()), 32'd0);
    check("rq_empty_end", 32'(rq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
